// File: rtl/io_responder_if.sv
// io_responder_if: processor IO-port bus between a processor (master) and
// the io_responder device (slave).
//   cs, rd, wr        select and access strobes (master -> slave)
//   ADDRESS, DATA_IN  byte address and write data (master -> slave)
//   out, rdy          read data and access-complete flag (slave -> master)
//   intr, intr_ack    interrupt request / acknowledge handshake
interface io_responder_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic [31:0] out;
  logic        rdy;
  logic        intr;
  logic        intr_ack;

  modport master (
    output cs, rd, wr, ADDRESS, DATA_IN, intr_ack,
    input  out, rdy, intr
  );

  modport slave (
    input  cs, rd, wr, ADDRESS, DATA_IN, intr_ack,
    output out, rdy, intr
  );
endinterface

// File: rtl/io_responder.sv
// io_responder: memory-mapped external I/O device on the processor IO port.
// Holds a word-addressed array of DEPTH 32-bit registers and answers every
// access WAIT_STATES+1 cycles after it is captured.
// Optional feature macro: IO_INTR_TIMER_EN adds a free-running interval
// timer that raises intr every INTR_PERIOD cycles until intr_ack.
// Ports:
//   sys_clk  system clock, rising edge
//   reset    asynchronous, active-high reset
//   bus      io_responder_if.slave (cs/rd/wr/ADDRESS/DATA_IN in,
//            out/rdy/intr out, intr_ack in)
//
// state | meaning
// IDLE  | waiting for cs with rd or wr; captures index, data and op
// WAIT  | counting down wait states; cs low aborts the access
// DONE  | access performed; rdy asserted while cs stays high
module io_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_STATES = 3,
  parameter int INTR_PERIOD = 1000
) (
  input logic           sys_clk,
  input logic           reset,
  io_responder_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;
  logic          r_op_rd, r_op_wr;
  logic [31:0]   r_out;
  logic          r_rdy;
  logic [31:0]   r_mem [DEPTH];

  logic          w_start, w_capture, w_access;
  logic [AW-1:0] w_live_idx, w_acc_idx;
  logic [31:0]   w_acc_data;
  logic          w_acc_rd, w_acc_wr;
  logic          w_unused_addr;

  assign w_start       = bus.cs & (bus.rd | bus.wr);
  assign w_live_idx    = bus.ADDRESS[AW+1:2];
  assign w_unused_addr = ^{bus.ADDRESS[31:AW+2], bus.ADDRESS[1:0]};

  // With zero wait states the access happens on the capture edge itself, so
  // the live bus values feed the array; otherwise the captured copies do.
  assign w_acc_idx  = (r_state == ST_IDLE) ? w_live_idx  : r_idx;
  assign w_acc_data = (r_state == ST_IDLE) ? bus.DATA_IN : r_data;
  assign w_acc_rd   = (r_state == ST_IDLE) ? bus.rd      : r_op_rd;
  assign w_acc_wr   = (r_state == ST_IDLE) ? bus.wr      : r_op_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_DONE;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 8'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!bus.cs) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd1) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 8'd0;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_DONE: begin
        if (!bus.cs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= '0;
      r_data  <= 32'd0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
      r_out   <= 32'd0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_idx   <= w_live_idx;
        r_data  <= bus.DATA_IN;
        r_op_rd <= bus.rd;
        r_op_wr <= bus.wr;
      end
      // rd&wr together is illegal: answer with zero instead of stalling the bus
      if (w_access && w_acc_rd)
        r_out <= w_acc_wr ? 32'd0 : r_mem[w_acc_idx];
      r_rdy <= (r_state == ST_DONE) && bus.cs;
    end
  end

  // Array is deliberately not reset so it can map onto RAM.
  always_ff @(posedge sys_clk) begin
    if (w_access && w_acc_wr && !w_acc_rd)
      r_mem[w_acc_idx] <= w_acc_data;
  end

  assign bus.out = r_out;
  assign bus.rdy = r_rdy;

`ifdef IO_INTR_TIMER_EN
  logic [31:0] r_timer;
  logic        r_intr;

  // A new expiry wins over an acknowledge on the same edge.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_timer <= 32'd0;
      r_intr  <= 1'b0;
    end else if (r_timer == 32'(INTR_PERIOD - 1)) begin
      r_timer <= 32'd0;
      r_intr  <= 1'b1;
    end else begin
      r_timer <= r_timer + 32'd1;
      if (bus.intr_ack) r_intr <= 1'b0;
    end
  end

  assign bus.intr = r_intr;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = bus.intr_ack ^ (INTR_PERIOD != 0);
  assign bus.intr     = 1'b0;
`endif

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed bench for io_responder with a scoreboard of
// expected read-back values (WAIT_STATES=3, INTR_PERIOD=8).
module tb_io_responder;
  localparam int WS = 3;
`ifdef IO_INTR_TIMER_EN
  localparam logic TMR = 1'b1;
`else
  localparam logic TMR = 1'b0;
`endif

  logic sys_clk;
  logic reset;
  io_responder_if bus();

  io_responder #(.DEPTH(1024), .AW(10), .WAIT_STATES(WS), .INTR_PERIOD(8)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mm [int];
  logic [31:0] model_out = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; ADDRESS/DATA_IN are scrambled after capture.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    int idx;
    int cyc;
    logic [31:0] e;
    idx = int'((a >> 2) & 32'h3FF);
    @(negedge sys_clk);
    bus.cs = 1'b1; bus.rd = r; bus.wr = w; bus.ADDRESS = a; bus.DATA_IN = d;
    if (r && w) model_out = 32'd0;
    else if (r) model_out = mm.exists(idx) ? mm[idx] : 32'hxxxxxxxx;
    else mm[idx] = d;
    exp_q.push_back(model_out);
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.ADDRESS = ~a; bus.DATA_IN = ~d;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge sys_clk); #1;
      cyc = i;
      if (bus.rdy === 1'b1) break;
    end
    if (bus.rdy !== 1'b1) cyc = 99;
    check({tag, "_latency"}, 32'(cyc), 32'(WS + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check({tag, "_out"}, bus.out, e);
    @(posedge sys_clk); #1;
    check({tag, "_rdy_hold"}, 32'(bus.rdy), 32'd1);
    @(negedge sys_clk);
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    @(posedge sys_clk); #1;
    check({tag, "_rdy_drop"}, 32'(bus.rdy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.ADDRESS = 32'd0; bus.DATA_IN = 32'd0; bus.intr_ack = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_out", bus.out, 32'd0);
    check("rst_rdy", 32'(bus.rdy), 32'd0);
    check("rst_intr", 32'(bus.intr), 32'd0);
    reset = 1'b0;

    // timer: expiries land on edges 8 and 16 after release
    repeat (7) @(posedge sys_clk);
    #1 check("intr_pre", 32'(bus.intr), 32'd0);
    check("rel_rdy", 32'(bus.rdy), 32'd0);
    check("rel_out", bus.out, 32'd0);
    @(posedge sys_clk); #1 check("intr_rise", 32'(bus.intr), 32'(TMR));
    @(negedge sys_clk); bus.intr_ack = 1'b1;
    @(posedge sys_clk); #1 check("intr_ack_clr", 32'(bus.intr), 32'd0);
    repeat (7) @(posedge sys_clk);
    #1 check("intr_ack_vs_expiry", 32'(bus.intr), 32'(TMR));
    @(negedge sys_clk); bus.intr_ack = 1'b0;
    @(posedge sys_clk); #1 check("intr_held", 32'(bus.intr), 32'(TMR));
    @(negedge sys_clk); bus.intr_ack = 1'b1;
    @(posedge sys_clk); #1 check("intr_ack_clr2", 32'(bus.intr), 32'd0);
    @(negedge sys_clk); bus.intr_ack = 1'b0;

    // strobes without cs are ignored
    bus.rd = 1'b1; bus.wr = 1'b1; bus.ADDRESS = 32'h10;
    repeat (6) @(posedge sys_clk);
    #1 check("nocs_rdy", 32'(bus.rdy), 32'd0);
    @(negedge sys_clk); bus.rd = 1'b0; bus.wr = 1'b0;

    access("wr10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access("rd10", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    access("wr_alias", 1'b0, 1'b1, 32'h0000_1007, 32'hA5A5_A5A5);
    access("rd_alias", 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    access("wr20", 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111);

    // abort after one WAIT cycle
    @(negedge sys_clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.ADDRESS = 32'h20; bus.DATA_IN = 32'h1234;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk); bus.cs = 1'b0; bus.wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1 check("abort_rdy", 32'(bus.rdy), 32'd0);
    end
    check("abort_out", bus.out, model_out);
    access("rd20", 1'b1, 1'b0, 32'h0000_0020, 32'h0);

    access("illegal", 1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555);
    access("rd10_after_ill", 1'b1, 1'b0, 32'h0000_0010, 32'h0);

    // reset pulse in WAIT: nothing committed
    access("wr30", 1'b0, 1'b1, 32'h0000_0030, 32'h2222_2222);
    @(negedge sys_clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.ADDRESS = 32'h30; bus.DATA_IN = 32'h3333_3333;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk); reset = 1'b1;
    #1 check("midrst_rdy", 32'(bus.rdy), 32'd0);
    check("midrst_out", bus.out, 32'd0);
    model_out = 32'd0;
    @(negedge sys_clk); reset = 1'b0; bus.cs = 1'b0; bus.wr = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 check("postrst_rdy", 32'(bus.rdy), 32'd0);
    access("rd30", 1'b1, 1'b0, 32'h0000_0030, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
